// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide engine; mul/div commit WIDTH+1 edges after accept, others one edge later.
// start is sampled only while not busy (ignored otherwise); divider built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 commit_q, commit_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 divzero_q, divzero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [2*WIDTH-1:0]   prod_fix;

  // Signed ops are the odd codes (MULT/DIV); only magnitudes enter the iteration.
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // p_q = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, p_q[WIDTH-1:1]};
  assign prod_fix = neg_q ? -p_q : p_q;

`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH:0]       div_r;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  // p_q = {remainder, dividend bits not yet consumed / quotient bits}; shift left, trial subtract.
  assign div_r    = p_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_r - {1'b0, opnd_q};
  assign div_step = div_diff[WIDTH] ? {div_r[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
  assign quot_fix = neg_q  ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    commit_d  = commit_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d  = is_div_q;
    rneg_d    = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FINISH;
          commit_d = 1'b0;
          dz_d     = 1'b0;
          neg_d    = a_neg ^ b_neg;
          cnt_d    = CW'(WIDTH);
          case (op)
            3'b000, 3'b001: begin
              state_d  = S_RUN;
              busy_d   = 1'b1;
              commit_d = 1'b1;
              p_d      = {{WIDTH{1'b0}}, b_mag};
              opnd_d   = a_mag;
`ifdef MULDIV_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            3'b010, 3'b011: begin
              if (b == '0) begin
                dz_d = 1'b1;
              end else begin
                state_d  = S_RUN;
                busy_d   = 1'b1;
                commit_d = 1'b1;
                p_d      = {{WIDTH{1'b0}}, a_mag};
                opnd_d   = b_mag;
                is_div_d = 1'b1;
                rneg_d   = a_neg;
              end
            end
`endif
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
`ifdef MULDIV_DIV_EN
        p_d = is_div_q ? div_step : mul_step;
`else
        p_d = mul_step;
`endif
        if (cnt_q == CW'(1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        divzero_d = dz_q;
        if (commit_q) begin
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
`else
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      commit_q  <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      commit_q  <= commit_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q  <= is_div_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 64-bit arithmetic reference model, randomized and directed ops.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         divzero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .divzero (divzero),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_hi, m_lo;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic predict(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output bit iter);
    exp_t        e;
    longint      sx, sy;
    logic [63:0] p;
    iter = 0;
    e.dz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = p; iter = 1; end
      3'd1: begin p = sx * sy; {m_hi, m_lo} = p; iter = 1; end
      3'd2, 3'd3: begin
`ifdef MULDIV_DIV_EN
        if (y == 0) begin
          e.dz = 1'b1;
        end else begin
          iter = 1;
          if (o == 3'd2) begin
            m_lo = x / y;
            m_hi = x % y;
          end else begin
            m_lo = 32'(sx / sy);
            m_hi = 32'(sx % sy);
          end
        end
`endif
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    bit           iter, got, hold_ok;
    int           lat, bcnt;
    logic [W-1:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    start = 1'b1; op = o; a = x; b = y;
    predict(o, x, y, iter);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    lat = 0; bcnt = 0; got = 0; hold_ok = 1;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) got = 1;
      else if (iter && (hi !== old_hi || lo !== old_lo)) hold_ok = 0;
      if (poke && lat == 10) begin
        start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
      end
      if (poke && lat == 11) start = 1'b0;
    end
    chk("done_seen", 64'(got), 64'd1);
    if (got) begin
      chk("done_latency", 64'(lat), iter ? 64'(W + 2) : 64'd2);
      chk("busy_cycles", 64'(bcnt), iter ? 64'(W + 1) : 64'd0);
      if (iter) chk("hold_until_commit", 64'(hold_ok), 64'd1);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("divzero", 64'(divzero), 64'(e.dz));
        end
      end
    end
  end

  initial begin
    int dcount;
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    clk = 0; reset = 0; start = 0; op = 0; a = 0; b = 0;
    m_hi = 0; m_lo = 0;

    #2 reset = 1'b1;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_divzero", 64'(divzero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(3'd4, 32'h12345678, 32'h0, 0);
    issue(3'd1, 32'hFFFFFFFD, 32'd5, 0);
    chk("mult_hi_const", 64'(m_hi), 64'hFFFFFFFF);
    chk("mult_lo_const", 64'(m_lo), 64'hFFFFFFF1);
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 0);
    issue(3'd2, 32'd100, 32'd7, 0);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    issue(3'd4, 32'hAAAA0000, 32'h0, 0);
    issue(3'd5, 32'h0000BBBB, 32'h0, 0);
    issue(3'd2, 32'h1234, 32'h0, 0);
    issue(3'd3, 32'h80000000, 32'h0, 0);
    issue(3'd6, 32'hDEADBEEF, 32'h1, 0);
    issue(3'd7, 32'hCAFEF00D, 32'h2, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      case ($urandom_range(0, 4))
        0:       ry = 32'h0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFFFFFF;
        default: ry = $urandom;
      endcase
      issue(ro, rx, ry, 0);
    end

    // Abort a MULTU mid-RUN with an asynchronous reset.
    start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    sb.delete();
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    issue(3'd1, 32'h00001234, 32'hFFFF0000, 0);
    issue(3'd1, $urandom, $urandom, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit that owns the HI/LO register pair for the MIPS core. It replaces the combinational single-cycle multiply in the ALU with a multi-cycle engine. The engine supports signed and unsigned multiply and divide, plus MTHI/MTLO writes. It sits beside the ALU in the execute stage. The controller stalls the PC while `busy` is high, and reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; must be ≥ 4 and even.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: request; sampled on rising edge only when `busy`=0.
- `op` input 3: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
- `a` input WIDTH: rs operand (dividend / multiplicand / MTHI-MTLO source).
- `b` input WIDTH: rt operand (divisor / multiplier).
- `busy` output 1: engine iterating; new `start` ignored.
- `done` output 1: one-cycle pulse; the operation has committed.
- `divzero` output 1: valid with `done`; divide with `b`=0.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- **State machine.** IDLE → RUN → FINISH → IDLE. Reset forces IDLE.
- **Accept.** In IDLE, `start`=1 at an edge latches `op`, `a`, `b`. A later change on the inputs has no effect.
- **MULTU/MULT.**
  - Shift-add over magnitudes.
  - MULT takes |a| and |b|, and negates the 2·WIDTH product if sign(a)≠sign(b).
  - `{hi,lo}` receives the full product.
- **DIVU/DIV.**
  - Restoring division over magnitudes.
  - `lo` = quotient, truncated toward zero.
  - `hi` = remainder, with the sign of the dividend.
  - DIV of most-negative ÷ −1 gives `lo`=most-negative and `hi`=0, with no flag.
- **Divide by zero.** If `b`=0 for DIV/DIVU, skip RUN and go straight to FINISH. `hi`/`lo` are unchanged and `divzero`=1.
- **MTHI/MTLO.**
  - Write `a` to `hi`/`lo` at the accepting edge.
  - Next state is FINISH, so `done` pulses and `busy` is never asserted.
- **No-op codes.** Accepted, go to FINISH, `done` pulses, no state change.
- **Signed handling.** Sign handling is done at latch (magnitudes) and at FINISH (negation), so RUN is sign-agnostic.
- **Iteration counter.** Width is clog2(WIDTH)+1. It wraps only via reload on accept.

## Timing
- **Reset values.** `hi`=0, `lo`=0, `busy`=0, `done`=0, `divzero`=0, state IDLE. Reset takes effect immediately, independent of `clk`.
- **Accepted at edge N (mul/div, b≠0):**
  - RUN performs one iteration per edge N+1 … N+WIDTH.
  - FINISH commits `hi`/`lo` at edge N+WIDTH+1.
- **busy.** High in the cycles after edges N … N+WIDTH, i.e. WIDTH+1 cycles. Low after edge N+WIDTH+1.
- **done / divzero.**
  - Registered; high for exactly the one cycle after the commit edge.
  - Divide-by-zero, MTHI/MTLO and no-op: `done` is high in the cycle after edge N+1.
- **hi/lo hold.** `hi`/`lo` hold their previous values throughout RUN. Readers see the old result until the commit edge.
- **Back-to-back.** `start` may be high in the same cycle `done` is high. It is accepted at that edge, because state is IDLE again.
- **start while busy.** Ignored, not queued.
- **Reset mid-RUN.** Aborts the operation; `hi`/`lo` go to 0; no `done`.

## Configuration
- `MULDIV_DIV_EN` defined: DIVU/DIV implemented as above.
- `MULDIV_DIV_EN` undefined:
  - No divider datapath is synthesised.
  - Op codes 010/011 are treated as no-ops: `done` pulses the cycle after edge N+1, `divzero`=0, `hi`/`lo` unchanged.

## Test plan
- **Reset values.** Assert `reset` asynchronously between edges. Required: `hi`=`lo`=0, `busy`=`done`=0 immediately. Then MTHI `a`=0x12345678: `hi`=0x12345678 one edge later, `done` one cycle, `busy` never high.
- **Signed multiply.** WIDTH=32, MULT `a`=0xFFFFFFFD (−3), `b`=5. Required: `busy` for 33 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `done` for one cycle.
- **Unsigned multiply.** MULTU `a`=`b`=0xFFFFFFFF. Required: `hi`=0xFFFFFFFE, `lo`=0x00000001. A second `start` pulsed mid-RUN is ignored and `hi`/`lo` keep their old values until commit.
- **Divide.**
  - DIV −7 ÷ 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 100 ÷ 7: `lo`=14, `hi`=2.
  - DIV 0x80000000 ÷ 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- **Divide by zero.** Preload `hi`=0xAAAA0000 and `lo`=0x0000BBBB, then DIVU `b`=0. Required: `done`=`divzero`=1 in the cycle after edge N+1, values unchanged. Without `MULDIV_DIV_EN`: `divzero`=0 and `hi`/`lo` unchanged.
- **Reset mid-RUN.** Assert `reset` 10 cycles into MULTU. Required: `busy`=0, `hi`=`lo`=0, no `done` pulse. A new MULT issued after release completes normally.
